// File: rtl/servant_mmcm_drp_ctrl_pkg.sv
// rtl/servant_mmcm_drp_ctrl_pkg.sv - shared types and constants for the MMCM DRP controller
package servant_mmcm_drp_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_ON,
    S_RD1,
    S_WR1,
    S_RD2,
    S_WR2,
    S_RELEASE,
    S_WAIT_LOCK,
    S_DONE
  } state_t;

  localparam logic [6:0]  REG1_ADDR = 7'h08;
  localparam logic [6:0]  REG2_ADDR = 7'h09;
  localparam logic [15:0] REG1_KEEP = 16'hF000;
  localparam logic [15:0] REG2_KEEP = 16'hFF3F;

  localparam logic [6:0] DIV_MIN = 7'd1;
  localparam logic [6:0] DIV_MAX = 7'd126;

  function automatic logic div_legal(input logic [6:0] d);
    return (d >= DIV_MIN) && (d <= DIV_MAX);
  endfunction

endpackage

// File: rtl/servant_mmcm_div_enc.sv
// rtl/servant_mmcm_div_enc.sv - CLKOUT divide to HIGH/LOW/EDGE/NO_COUNT field encoder
module servant_mmcm_div_enc (
  input  logic [6:0] i_div,
  output logic [5:0] o_high,
  output logic [5:0] o_low,
  output logic       o_edge,
  output logic       o_no_count
);

  // LOW = d - (d>>1) is the same as (d>>1) + d[0], which stays within 6 bits
  always_comb begin
    o_high     = i_div[6:1];
    o_low      = i_div[6:1] + {5'd0, i_div[0]};
    o_edge     = i_div[0];
    o_no_count = 1'b0;
    if (i_div == 7'd1) begin
      o_high     = 6'd1;
      o_low      = 6'd1;
      o_edge     = 1'b0;
      o_no_count = 1'b1;
    end
  end

endmodule

// File: rtl/servant_mmcm_drp_ctrl.sv
// rtl/servant_mmcm_drp_ctrl.sv - MMCM CLKOUT0 reconfiguration sequencer over DRP
module servant_mmcm_drp_ctrl
  import servant_mmcm_drp_ctrl_pkg::*;
#(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [6:0]  i_div,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [6:0]  o_daddr,
  output logic [15:0] o_di,
  input  logic [15:0] i_do,
  output logic        o_den,
  output logic        o_dwe,
  input  logic        i_drdy,
  output logic        o_mmcm_rst,
  input  logic        i_locked,
  output logic        o_rst
);

  localparam int MAX_TO = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_W  = $clog2(MAX_TO + 1);
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_t           r_state;
  logic [1:0]       r_sync;
  logic [6:0]       r_div;
  logic [CNT_W-1:0] r_cnt;

  logic       w_locked_s;
  logic [5:0] w_high;
  logic [5:0] w_low;
  logic       w_edge;
  logic       w_no_count;

  assign w_locked_s = r_sync[1];

  servant_mmcm_div_enc u_div_enc (
    .i_div      (r_div),
    .o_high     (w_high),
    .o_low      (w_low),
    .o_edge     (w_edge),
    .o_no_count (w_no_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_sync     <= 2'b00;
      r_div      <= 7'd0;
      r_cnt      <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_daddr    <= 7'd0;
      o_di       <= 16'd0;
      o_den      <= 1'b0;
      o_dwe      <= 1'b0;
      o_mmcm_rst <= 1'b0;
      o_rst      <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_locked};
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_rst <= !w_locked_s;
          if (i_req) begin
            r_div  <= i_div;
            o_busy <= 1'b1;
            if (div_legal(i_div)) begin
              o_err   <= 1'b0;
              r_state <= S_RST_ON;
            end else begin
              o_err   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_RST_ON: begin
          o_rst      <= 1'b1;
          o_mmcm_rst <= 1'b1;
          o_den      <= 1'b1;
          o_dwe      <= 1'b0;
          o_daddr    <= REG1_ADDR;
          r_cnt      <= '0;
          r_state    <= S_RD1;
        end

        // o_den is high only in the first cycle of a DRP state; i_drdy is ignored there
        S_RD1, S_WR1, S_RD2, S_WR2: begin
          if (o_den) begin
            o_den <= 1'b0;
            o_dwe <= 1'b0;
            r_cnt <= r_cnt + CNT_W'(1);
          end else if (i_drdy) begin
            r_cnt <= '0;
            case (r_state)
              S_RD1: begin
                o_den   <= 1'b1;
                o_dwe   <= 1'b1;
                o_daddr <= REG1_ADDR;
                o_di    <= (i_do & REG1_KEEP) | {4'd0, w_high, w_low};
                r_state <= S_WR1;
              end
              S_WR1: begin
                o_den   <= 1'b1;
                o_dwe   <= 1'b0;
                o_daddr <= REG2_ADDR;
                r_state <= S_RD2;
              end
              S_RD2: begin
                o_den   <= 1'b1;
                o_dwe   <= 1'b1;
                o_daddr <= REG2_ADDR;
                o_di    <= (i_do & REG2_KEEP) | {8'd0, w_edge, w_no_count, 6'd0};
                r_state <= S_WR2;
              end
              default: r_state <= S_RELEASE;
            endcase
          end else if (r_cnt == DRDY_LAST) begin
            o_err      <= 1'b1;
            o_mmcm_rst <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RELEASE: begin
          o_mmcm_rst <= 1'b0;
          r_cnt      <= '0;
          r_state    <= S_WAIT_LOCK;
        end

        S_WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= S_DONE;
          end else if (r_cnt == LOCK_LAST) begin
            o_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servant_mmcm_drp_ctrl.sv
// tb/tb_servant_mmcm_drp_ctrl.sv - self-checking bench for servant_mmcm_drp_ctrl
module tb_servant_mmcm_drp_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req;
  logic [6:0]  i_div;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [6:0]  o_daddr;
  logic [15:0] o_di;
  logic [15:0] i_do;
  logic        o_den;
  logic        o_dwe;
  logic        i_drdy;
  logic        o_mmcm_rst;
  logic        i_locked;
  logic        o_rst;

  servant_mmcm_drp_ctrl dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_div      (i_div),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_daddr    (o_daddr),
    .o_di       (o_di),
    .i_do       (i_do),
    .o_den      (o_den),
    .o_dwe      (o_dwe),
    .i_drdy     (i_drdy),
    .o_mmcm_rst (o_mmcm_rst),
    .i_locked   (i_locked),
    .o_rst      (o_rst)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] data;
  } drp_t;

  typedef struct {
    logic [6:0]  div;
    logic [15:0] rb1;
    logic [15:0] rb2;
    logic [15:0] wr1;
    logic [15:0] wr2;
    logic        err;
  } vec_t;

  drp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_den  = 0;
  logic [15:0] rb1    = 16'h0000;
  logic [15:0] rb2    = 16'h0000;
  logic        hold_wr1  = 1'b0;
  logic        auto_lock = 1'b0;
  logic        man_lock  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_seq(input logic [15:0] w1, input logic [15:0] w2);
    exp_q.push_back('{we: 1'b0, addr: 7'h08, data: 16'h0});
    exp_q.push_back('{we: 1'b1, addr: 7'h08, data: w1});
    exp_q.push_back('{we: 1'b0, addr: 7'h09, data: 16'h0});
    exp_q.push_back('{we: 1'b1, addr: 7'h09, data: w2});
  endtask

  // DRP slave: pops the expected transaction, returns i_drdy one cycle after o_den
  initial begin
    drp_t e;
    i_drdy = 1'b0;
    i_do   = 16'h0;
    forever begin
      @(negedge i_clk);
      i_drdy = 1'b0;
      if (o_den === 1'b1) begin
        n_den++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_den: got addr 0x%0h we %0b expected no transaction", o_daddr, o_dwe);
        end else begin
          e = exp_q.pop_front();
          chk("drp_we", o_dwe, e.we);
          chk("drp_addr", o_daddr, e.addr);
          if (e.we) chk("drp_wdata", o_di, e.data);
        end
        if (!(hold_wr1 && o_dwe && o_daddr == 7'h08)) begin
          @(negedge i_clk);
          i_drdy = 1'b1;
          i_do   = (o_daddr == 7'h08) ? rb1 : rb2;
        end
      end
    end
  end

  // MMCM lock model: drops lock in reset, relocks 11 cycles after release when automatic
  initial begin
    int lk_cnt;
    lk_cnt   = 0;
    i_locked = 1'b0;
    forever begin
      @(posedge i_clk);
      #2;
      if (o_mmcm_rst) begin
        i_locked = 1'b0;
        lk_cnt   = 0;
      end else if (auto_lock) begin
        if (lk_cnt < 10) lk_cnt++;
        else i_locked = 1'b1;
      end else begin
        i_locked = man_lock;
      end
    end
  end

  task automatic wait_core_rst_low(input string name);
    logic got;
    got = !o_rst;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge i_clk); #1;
      got = !o_rst;
    end
    chk(name, got, 1'b1);
  endtask

  task automatic run_req(input logic [6:0] d, input logic exp_err);
    logic got;
    @(posedge i_clk); #1;
    i_req = 1'b1;
    i_div = d;
    @(posedge i_clk); #1;
    i_req = 1'b0;
    chk("busy_after_req", o_busy, 1'b1);
    chk("err_at_accept", o_err, exp_err);
    @(posedge i_clk); #1;
    chk("mmcm_rst_at_2", o_mmcm_rst, !exp_err);
    chk("done_at_2", o_done, exp_err);
    chk("core_rst_at_2", o_rst, !exp_err);
    got = o_done;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(posedge i_clk); #1;
      got = o_done;
    end
    chk("done_seen", got, 1'b1);
    chk("err_final", o_err, exp_err);
    chk("busy_final", o_busy, 1'b0);
    chk("mmcm_rst_final", o_mmcm_rst, 1'b0);
    chk("sb_empty", exp_q.size(), 0);
    @(posedge i_clk); #1;
    chk("done_one_cycle", o_done, 1'b0);
    wait_core_rst_low("core_rst_release");
  endtask

  vec_t vecs[8];

  initial begin
    int   den0;
    int   elapsed;
    logic got;

    vecs[0] = '{div: 7'd50,  rb1: 16'hA000, rb2: 16'h0000, wr1: 16'hA659, wr2: 16'h0000, err: 1'b0};
    vecs[1] = '{div: 7'd0,   rb1: 16'h0000, rb2: 16'h0000, wr1: 16'h0000, wr2: 16'h0000, err: 1'b1};
    vecs[2] = '{div: 7'd1,   rb1: 16'h0000, rb2: 16'h0000, wr1: 16'h0041, wr2: 16'h0040, err: 1'b0};
    vecs[3] = '{div: 7'd127, rb1: 16'h0000, rb2: 16'h0000, wr1: 16'h0000, wr2: 16'h0000, err: 1'b1};
    vecs[4] = '{div: 7'd7,   rb1: 16'h5FFF, rb2: 16'hFFFF, wr1: 16'h50C4, wr2: 16'hFFBF, err: 1'b0};
    vecs[5] = '{div: 7'd126, rb1: 16'h3123, rb2: 16'h00C0, wr1: 16'h3FFF, wr2: 16'h0000, err: 1'b0};
    vecs[6] = '{div: 7'd2,   rb1: 16'hFFFF, rb2: 16'h1234, wr1: 16'hF041, wr2: 16'h1234, err: 1'b0};
    vecs[7] = '{div: 7'd3,   rb1: 16'h0000, rb2: 16'h0040, wr1: 16'h0042, wr2: 16'h0080, err: 1'b0};

    i_rst = 1'b1;
    i_req = 1'b0;
    i_div = 7'd0;

    // power-up: reset values, then o_rst follows lock three cycles late
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_daddr", o_daddr, 7'd0);
    chk("rst_di", o_di, 16'd0);
    chk("rst_den", o_den, 1'b0);
    chk("rst_dwe", o_dwe, 1'b0);
    chk("rst_mmcm_rst", o_mmcm_rst, 1'b0);
    chk("rst_core_rst", o_rst, 1'b1);
    i_rst = 1'b0;
    repeat (20) @(posedge i_clk);
    #1;
    man_lock = 1'b1;
    @(posedge i_clk); #1;
    chk("pwrup_core_rst_c1", o_rst, 1'b1);
    @(posedge i_clk); #1;
    chk("pwrup_core_rst_c2", o_rst, 1'b1);
    @(posedge i_clk); #1;
    chk("pwrup_core_rst_c3", o_rst, 1'b0);
    chk("pwrup_no_den", n_den, 0);
    auto_lock = 1'b1;

    for (int v = 0; v < 8; v++) begin
      rb1 = vecs[v].rb1;
      rb2 = vecs[v].rb2;
      if (!vecs[v].err) push_seq(vecs[v].wr1, vecs[v].wr2);
      den0 = n_den;
      run_req(vecs[v].div, vecs[v].err);
      chk("den_count", n_den - den0, vecs[v].err ? 0 : 4);
    end

    // DRP write to REG1 never acknowledged; a request while busy must be dropped
    rb1 = 16'h0000;
    hold_wr1 = 1'b1;
    exp_q.push_back('{we: 1'b0, addr: 7'h08, data: 16'h0});
    exp_q.push_back('{we: 1'b1, addr: 7'h08, data: 16'h0042});
    den0 = n_den;
    @(posedge i_clk); #1;
    i_req = 1'b1;
    i_div = 7'd3;
    @(posedge i_clk); #1;
    i_req = 1'b0;
    got = 1'b0;
    elapsed = 0;
    for (int i = 1; i < 300 && !got; i++) begin
      @(posedge i_clk); #1;
      i_req = (i == 10);
      i_div = 7'd5;
      got = o_done;
      elapsed = i;
    end
    i_req = 1'b0;
    chk("to_done_seen", got, 1'b1);
    chk("to_err", o_err, 1'b1);
    chk("to_mmcm_rst", o_mmcm_rst, 1'b0);
    chk("to_len_min", elapsed >= 64, 1'b1);
    chk("to_len_max", elapsed <= 72, 1'b1);
    chk("to_sb_empty", exp_q.size(), 0);
    hold_wr1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge i_clk); #1;
      if (o_busy) got = 1'b1;
    end
    chk("busy_req_ignored", got, 1'b0);
    chk("to_den_count", n_den - den0, 2);
    wait_core_rst_low("to_core_rst_release");

    // asynchronous reset while waiting for lock
    auto_lock = 1'b0;
    man_lock  = 1'b0;
    rb1 = 16'hA000;
    rb2 = 16'h0000;
    push_seq(16'hA659, 16'h0000);
    @(posedge i_clk); #1;
    i_req = 1'b1;
    i_div = 7'd50;
    @(posedge i_clk); #1;
    i_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge i_clk); #1;
      got = o_mmcm_rst;
    end
    for (int i = 0; i < 200 && got; i++) begin
      @(posedge i_clk); #1;
      got = o_mmcm_rst;
    end
    chk("wl_reached", got, 1'b0);
    chk("wl_busy", o_busy, 1'b1);
    chk("wl_sb_empty", exp_q.size(), 0);
    repeat (5) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    chk("ar_mmcm_rst", o_mmcm_rst, 1'b0);
    chk("ar_busy", o_busy, 1'b0);
    chk("ar_core_rst", o_rst, 1'b1);
    chk("ar_done", o_done, 1'b0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    auto_lock = 1'b1;
    wait_core_rst_low("ar_core_rst_release");
    chk("ar_idle", o_busy, 1'b0);

    rb1 = vecs[4].rb1;
    rb2 = vecs[4].rb2;
    push_seq(vecs[4].wr1, vecs[4].wr2);
    den0 = n_den;
    run_req(vecs[4].div, 1'b0);
    chk("ar_next_den_count", n_den - den0, 4);

    repeat (3) @(posedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

endmodule

// File: doc/servant_mmcm_drp_ctrl.md
# servant_mmcm_drp_ctrl

Dynamic-reconfiguration controller for the board MMCM that generates the servant core clock. It accepts a requested CLKOUT0 integer divide and runs the full DRP sequence: hold the MMCM in reset, read-modify-write the two CLKOUT0 divider registers, release reset and wait for lock. It drives the core reset until the new clock is stable. It runs on the free-running input clock, not on the MMCM output.

## Interface
- DRDY_TIMEOUT, 64: cycles to wait for i_drdy before aborting with error
- LOCK_TIMEOUT, 65535: cycles to wait for lock after MMCM reset release
- i_clk  in  1  free-running reference clock; also used as DCLK
- i_rst  in  1  reset, asynchronous, active-high
- i_req  in  1  start reconfiguration; sampled only in IDLE
- i_div  in  7  requested CLKOUT0 divide, legal 1..126; captured with i_req
- o_busy  out  1  sequence in progress
- o_done  out  1  one-cycle pulse on completion (success or error)
- o_err  out  1  error status of last sequence; held until next accepted i_req
- o_daddr  out  7  DRP address
- o_di  out  16  DRP write data
- i_do  in  16  DRP read data
- o_den  out  1  DRP enable, single-cycle pulse
- o_dwe  out  1  DRP write enable, only together with o_den
- i_drdy  in  1  DRP ready
- o_mmcm_rst  out  1  MMCM RST
- i_locked  in  1  MMCM LOCKED, asynchronous
- o_rst  out  1  core reset, active-high

## Operation
- Reset values: o_busy 0, o_done 0, o_err 0, o_daddr 0, o_di 0, o_den 0, o_dwe 0, o_mmcm_rst 0, o_rst 1; state IDLE.
- i_locked passes through a 2-flop synchronizer (locked_s). In IDLE, o_rst = !locked_s, registered.
- Divider encoding from captured div d:
  - d = 1: HIGH = 1, LOW = 1, NO_COUNT = 1, EDGE = 0.
  - d ≥ 2: HIGH = d>>1, LOW = d − HIGH, EDGE = d[0], NO_COUNT = 0.
- REG1 at 0x08: bits [11:6] = HIGH, [5:0] = LOW; bits [15:12] are preserved from readback.
- REG2 at 0x09: bit 7 = EDGE, bit 6 = NO_COUNT; all other bits preserved.
- States:
  - IDLE: on i_req, capture i_div and clear o_err.
    - If d is 0 or 127, go to DONE with error and do not touch the MMCM.
    - Otherwise go to RST_ON.
  - RST_ON: assert o_rst and o_mmcm_rst, then go to RD1.
  - RD1 / WR1 / RD2 / WR2: issue one DRP transaction each, then wait for i_drdy.
    - Read data is latched on i_drdy.
    - The write word is the latched data with the field mask applied.
  - RELEASE: deassert o_mmcm_rst, clear the lock counter, go to WAIT_LOCK.
  - WAIT_LOCK: when locked_s = 1, go to DONE. If the counter reaches LOCK_TIMEOUT, go to DONE with error.
  - DONE: pulse o_done for one cycle, then go to IDLE. o_rst then follows !locked_s.
- DRP timeout: if DRDY_TIMEOUT cycles pass without i_drdy, set o_err, deassert o_mmcm_rst and go to DONE. o_rst stays asserted while !locked_s.
- o_busy = 1 in every state except IDLE.
- i_req while busy is ignored.
- i_drdy arriving when no transaction is outstanding is ignored.
- Asynchronous reset mid-sequence returns all outputs to their reset values immediately. The MMCM leaves its own reset, and o_rst deasserts only after lock is seen through the synchronizer.

## Timing
- o_den/o_dwe are asserted for exactly one cycle, in the first cycle of each DRP state. o_daddr/o_di are stable from that cycle until i_drdy.
- i_drdy is accepted at the earliest in the cycle after o_den. The next transaction starts in the cycle after i_drdy.
- i_req to o_mmcm_rst high: 2 cycles.
- With i_drdy returned 1 cycle after each o_den, i_req to RELEASE takes 11 cycles.
- o_rst deasserts 1 cycle after locked_s rises, which is 3 cycles after i_locked rises.
- An illegal divide gives o_done 2 cycles after i_req, with o_err = 1.

## Structure
- A shared package holds:
  - state enum and DRP addresses (REG1 = 0x08, REG2 = 0x09);
  - field masks (REG1_KEEP = 0xF000, REG2_KEEP = 0xFF3F);
  - the divide legality limits.
- One natural sub-module, servant_mmcm_div_enc: combinational d → {HIGH, LOW, EDGE, NO_COUNT}.
- A single FSM plus one shared timeout counter, wide enough for max(DRDY_TIMEOUT, LOCK_TIMEOUT).

## Test plan
- Power-up: assert i_rst, release; i_locked rises at cycle 20 → o_rst = 1 until cycle 23, then 0; no o_den.
- i_div = 50 with DRP model readback REG1 = 0xA000, REG2 = 0x0000 → writes REG1 = 0xA659 (HIGH 25, LOW 25) and REG2 = 0x0000. Then o_done with o_err = 0 and o_rst released after relock.
- i_div = 1 → REG1 low 12 bits = 0x041, REG2 bit 6 = 1. i_div = 7 → HIGH 3, LOW 4, EDGE = 1.
- i_div = 0, and separately i_div = 127 → o_done with o_err = 1, no o_den, o_mmcm_rst stays 0.
- DRP model withholds i_drdy on WR1 → after 64 cycles o_err = 1 and o_mmcm_rst = 0. A second i_req issued while busy is ignored.
- Assert i_rst during WAIT_LOCK → o_mmcm_rst = 0, o_busy = 0, o_rst = 1 immediately; the next request completes normally.
